harvard_cpu_core: RTL and testbench

// - Parametrised multi-cycle Harvard CPU core: width/depth-generalised successor of the 8-bit harvardcpu top.
// - Separate program port (async-read ROM) and data-memory port with a cmd/ready handshake; split rdata/wdata replaces the inout bus.
// - Integrates register file, ALU, Z/C flags and control FSM in one block; sits between program ROM and data RAM at system top.

---
 rtl/harvard_cpu_core.sv | 159 +++++++++++++++
 tb/tb_harvard_cpu_core.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/harvard_cpu_core.sv
// harvard_cpu_core: multi-cycle Harvard CPU (FETCH/EXEC/MEM/HALT) with register file, ALU and Z/C flags.
// Define HCPU_MULT_EN to turn opcode A into MUL; otherwise opcode A behaves as NOP.
module harvard_cpu_core #(
    parameter int unsigned DW   = 8,
    parameter int unsigned NREG = 4,
    parameter int unsigned PAW  = 8,
    localparam int unsigned RAW = $clog2(NREG),
    localparam int unsigned IW  = 4 + 2 * RAW + DW
) (
    input  logic           clk,
    input  logic           rst_n,
    output logic [PAW-1:0] prog_addr,
    input  logic [IW-1:0]  prog_data,
    output logic [1:0]     mem_cmd,
    output logic [DW-1:0]  mem_addr,
    output logic [DW-1:0]  mem_wdata,
    input  logic [DW-1:0]  mem_rdata,
    input  logic           mem_ready,
    output logic           halted
);

    typedef enum logic [1:0] {S_FETCH, S_EXEC, S_MEM, S_HALT} state_e;
    typedef enum logic [1:0] {CMD_IDLE = 2'b00, CMD_READ = 2'b01, CMD_WRITE = 2'b10} cmd_e;
    typedef enum logic [3:0] {
        OP_NOP = 4'h0, OP_LDI, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_LD,
        OP_ST, OP_JMP, OP_MUL, OP_JZ, OP_JC, OP_RSV_D, OP_RSV_E, OP_HLT
    } opcode_e;

    state_e         state_q, state_d;
    logic [PAW-1:0] pc_q, pc_d;
    logic [IW-1:0]  ir_q, ir_d;
    logic [DW-1:0]  regs_q [NREG];
    logic [DW-1:0]  regs_d [NREG];
    logic           z_q, z_d, c_q, c_d;
    cmd_e           mem_cmd_q, mem_cmd_d;
    logic [DW-1:0]  mem_addr_q, mem_addr_d;
    logic [DW-1:0]  mem_wdata_q, mem_wdata_d;

    opcode_e        op;
    logic [RAW-1:0] rd, rs;
    logic [DW-1:0]  imm, rd_val, rs_val, res;
    logic [DW:0]    sum_w, diff_w;
    logic [PAW-1:0] jmp_tgt;
    logic           wr;

    assign op      = opcode_e'(ir_q[IW-1 -: 4]);
    assign rd      = ir_q[IW-5 -: RAW];
    assign rs      = ir_q[IW-5-RAW -: RAW];
    assign imm     = ir_q[DW-1:0];
    assign rd_val  = regs_q[rd];
    assign rs_val  = regs_q[rs];
    assign sum_w   = {1'b0, rd_val} + {1'b0, rs_val};
    // Top bit of the extended difference is the unsigned borrow (rd < rs).
    assign diff_w  = {1'b0, rd_val} - {1'b0, rs_val};
    assign jmp_tgt = PAW'(imm);

`ifdef HCPU_MULT_EN
    logic [2*DW-1:0] prod;
    assign prod = {{DW{1'b0}}, rd_val} * {{DW{1'b0}}, rs_val};
`endif

    assign prog_addr = pc_q;
    assign mem_cmd   = mem_cmd_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign halted    = (state_q == S_HALT);

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ir_d        = ir_q;
        regs_d      = regs_q;
        z_d         = z_q;
        c_d         = c_q;
        mem_cmd_d   = mem_cmd_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        res         = '0;
        wr          = 1'b0;
        case (state_q)
            S_FETCH: begin
                ir_d    = prog_data;
                pc_d    = pc_q + PAW'(1);
                state_d = S_EXEC;
            end
            S_EXEC: begin
                state_d = S_FETCH;
                case (op)
                    OP_LDI: begin res = imm;                        c_d = 1'b0;        wr = 1'b1; end
                    OP_ADD: begin res = sum_w[DW-1:0];              c_d = sum_w[DW];   wr = 1'b1; end
                    OP_SUB: begin res = diff_w[DW-1:0];             c_d = diff_w[DW];  wr = 1'b1; end
                    OP_AND: begin res = rd_val & rs_val;            c_d = 1'b0;        wr = 1'b1; end
                    OP_OR:  begin res = rd_val | rs_val;            c_d = 1'b0;        wr = 1'b1; end
                    OP_XOR: begin res = rd_val ^ rs_val;            c_d = 1'b0;        wr = 1'b1; end
`ifdef HCPU_MULT_EN
                    OP_MUL: begin res = prod[DW-1:0]; c_d = |prod[2*DW-1:DW]; wr = 1'b1; end
`endif
                    OP_LD: begin
                        mem_cmd_d  = CMD_READ;
                        mem_addr_d = imm;
                        state_d    = S_MEM;
                    end
                    OP_ST: begin
                        mem_cmd_d   = CMD_WRITE;
                        mem_addr_d  = imm;
                        mem_wdata_d = rd_val;
                        state_d     = S_MEM;
                    end
                    OP_JMP: pc_d = jmp_tgt;
                    OP_JZ:  if (z_q) pc_d = jmp_tgt;
                    OP_JC:  if (c_q) pc_d = jmp_tgt;
                    OP_HLT: state_d = S_HALT;
                    default: ;
                endcase
            end
            S_MEM: begin
                if (mem_ready) begin
                    mem_cmd_d = CMD_IDLE;
                    state_d   = S_FETCH;
                    if (mem_cmd_q == CMD_READ) begin
                        res = mem_rdata;
                        wr  = 1'b1;
                    end
                end
            end
            S_HALT: ;
        endcase
        // Shared commit path: ALU ops in EXEC, LD on its ready cycle.
        if (wr) begin
            regs_d[rd] = res;
            z_d        = (res == '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_FETCH;
            pc_q        <= '0;
            ir_q        <= '0;
            regs_q      <= '{default: '0};
            z_q         <= 1'b0;
            c_q         <= 1'b0;
            mem_cmd_q   <= CMD_IDLE;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            regs_q      <= regs_d;
            z_q         <= z_d;
            c_q         <= c_d;
            mem_cmd_q   <= mem_cmd_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

endmodule

// File: tb/tb_harvard_cpu_core.sv
// Testbench for harvard_cpu_core: ISA-level reference model feeds an expected-transaction queue
// that a memory-port monitor drains; also checks reset, cycle counts and halt behaviour.
`timescale 1ns/1ps
module tb_harvard_cpu_core;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  prog_addr;
    logic [15:0] prog_data;
    logic [1:0]  mem_cmd;
    logic [7:0]  mem_addr, mem_wdata, mem_rdata;
    logic        mem_ready;
    logic        halted;

    logic [15:0] rom  [256];
    logic [7:0]  dmem [256];

    int checks = 0;
    int errors = 0;
    int fixed_lat = -1;
    int wait_total = 0;
    int pa = 0;

    typedef struct {
        logic [1:0] cmd;
        logic [7:0] addr;
        logic [7:0] data;
    } txn_t;
    txn_t exp_q[$];

    harvard_cpu_core #(.DW(8), .NREG(4), .PAW(8)) dut (
        .clk(clk), .rst_n(rst_n), .prog_addr(prog_addr), .prog_data(prog_data),
        .mem_cmd(mem_cmd), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .halted(halted)
    );

    assign prog_data = rom[prog_addr];

    initial forever #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, req);
        end
    endtask

    // Data memory: random wait states per command; ready/rdata are junk outside a command.
    initial begin
        int  w;
        int  lat;
        bit  busy;
        w = 0; lat = 0; busy = 0;
        mem_ready = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && mem_cmd != 2'b00) begin
                if (!busy) begin
                    busy = 1;
                    w    = 0;
                    lat  = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 3));
                end
                if (w < lat) begin
                    mem_ready = 1'b0;
                    mem_rdata = 8'($urandom);
                    w++;
                    wait_total++;
                end else begin
                    mem_ready = 1'b1;
                    mem_rdata = dmem[mem_addr];
                    if (mem_cmd == 2'b10) dmem[mem_addr] = mem_wdata;
                    busy = 0;
                end
            end else begin
                busy      = 0;
                mem_ready = 1'($urandom_range(0, 1));
                mem_rdata = 8'($urandom);
            end
        end
    end

    // Monitor: pops expected transactions on completion, checks hold stability and idle gap.
    initial begin
        logic [1:0] pcmd;
        logic [7:0] paddr, pwd;
        bit         pwait, pdone;
        txn_t       t;
        pwait = 0; pdone = 0; pcmd = '0; paddr = '0; pwd = '0;
        forever begin
            @(negedge clk);
            #1;
            if (rst_n !== 1'b1) begin
                pwait = 0;
                pdone = 0;
            end else begin
                if (pdone) check("idle_gap_cmd", mem_cmd, 2'b00);
                pdone = 0;
                if (mem_cmd != 2'b00) begin
                    if (pwait) begin
                        check("hold_cmd", mem_cmd, pcmd);
                        check("hold_addr", mem_addr, paddr);
                        if (pcmd == 2'b10) check("hold_wdata", mem_wdata, pwd);
                    end
                    if (mem_ready) begin
                        if (exp_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected_txn: actual cmd=%0b addr=0x%0h required none", mem_cmd, mem_addr);
                        end else begin
                            t = exp_q.pop_front();
                            check("txn_cmd", mem_cmd, t.cmd);
                            check("txn_addr", mem_addr, t.addr);
                            if (t.cmd == 2'b10) check("txn_wdata", mem_wdata, t.data);
                        end
                        pdone = 1;
                        pwait = 0;
                    end else begin
                        pwait = 1;
                        pcmd  = mem_cmd;
                        paddr = mem_addr;
                        pwd   = mem_wdata;
                    end
                end else begin
                    pwait = 0;
                end
            end
        end
    end

    // Instruction-set interpreter over rom/dmem; queues every memory access the program makes.
    task automatic model_run(output int cycles, output int hlt_pc);
        int r [4];
        int z, c, pc, steps, op, rd, rs, imm, a, b, res;
        bit wr, done;
        logic [7:0]  m [256];
        logic [15:0] ins;
        m = dmem;
        foreach (r[i]) r[i] = 0;
        z = 0; c = 0; pc = 0; steps = 0; done = 0; cycles = 0; hlt_pc = 0; res = 0;
        while (!done && steps < 5000) begin
            ins = rom[pc];
            pc = (pc + 1) % 256;
            steps++;
            cycles += 2;
            op = int'(ins[15:12]); rd = int'(ins[11:10]); rs = int'(ins[9:8]); imm = int'(ins[7:0]);
            a = r[rd]; b = r[rs]; wr = 0;
            case (op)
                1:  begin res = imm;               c = 0;             wr = 1; end
                2:  begin res = (a + b) % 256;     c = (a + b > 255); wr = 1; end
                3:  begin res = (a - b + 256) % 256; c = (a < b);     wr = 1; end
                4:  begin res = a & b;             c = 0;             wr = 1; end
                5:  begin res = a | b;             c = 0;             wr = 1; end
                6:  begin res = a ^ b;             c = 0;             wr = 1; end
                7:  begin
                        cycles++;
                        exp_q.push_back('{2'b01, 8'(imm), 8'h00});
                        res = int'(m[imm]);
                        wr = 1;
                    end
                8:  begin
                        cycles++;
                        exp_q.push_back('{2'b10, 8'(imm), 8'(a)});
                        m[imm] = 8'(a);
                    end
                9:  pc = imm;
                10: begin
`ifdef HCPU_MULT_EN
                        res = (a * b) % 256;
                        c = (a * b > 255);
                        wr = 1;
`endif
                    end
                11: if (z != 0) pc = imm;
                12: if (c != 0) pc = imm;
                15: begin done = 1; hlt_pc = pc; end
                default: ;
            endcase
            if (wr) begin
                r[rd] = res;
                z = (res == 0);
            end
        end
        check("model_halts", done, 1);
    endtask

    task automatic emit(input int op, input int rd, input int rs, input int imm);
        logic [3:0] o;
        logic [1:0] d, s;
        logic [7:0] i;
        logic [7:0] adr;
        o = 4'(op); d = 2'(rd); s = 2'(rs); i = 8'(imm); adr = 8'(pa);
        rom[adr] = {o, d, s, i};
        pa++;
    endtask

    task automatic clear_rom();
        foreach (rom[i]) rom[i] = 16'hF000;
        pa = 0;
    endtask

    // Exposes Z and C as present/absent stores to base and base+1.
    task automatic probe(input int base);
        emit(11, 0, 0, pa + 2);
        emit(8, 0, 0, base);
        emit(12, 0, 0, pa + 2);
        emit(8, 0, 0, base + 1);
    endtask

    task automatic dump(input int base);
        for (int i = 0; i < 4; i++) emit(8, i, 0, base + i);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_prog_addr"}, prog_addr, 8'h00);
        check({tag, "_mem_cmd"}, mem_cmd, 2'b00);
        check({tag, "_mem_addr"}, mem_addr, 8'h00);
        check({tag, "_mem_wdata"}, mem_wdata, 8'h00);
        check({tag, "_halted"}, halted, 1'b0);
    endtask

    task automatic run_prog(input string tag);
        int mc, hpc, cyc;
        model_run(mc, hpc);
        wait_total = 0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check({tag, "_release_pc"}, prog_addr, 8'h00);
        cyc = 0;
        while (halted !== 1'b1 && cyc < 4000) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check({tag, "_halted"}, halted, 1'b1);
        check({tag, "_cycles"}, cyc, mc + wait_total);
        check({tag, "_txn_left"}, exp_q.size(), 0);
        exp_q.delete();
        repeat (20) begin
            @(negedge clk);
            #2;
            check({tag, "_halt_pc"}, prog_addr, 8'(hpc));
            check({tag, "_halt_cmd"}, mem_cmd, 2'b00);
            check({tag, "_halt_flag"}, halted, 1'b1);
        end
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
    endtask

    task automatic gen_random();
        int k, n, sel;
        clear_rom();
        dump(8'h40);
        probe(8'h44);
        n = $urandom_range(15, 30);
        repeat (n) begin
            k = $urandom_range(0, 11);
            case (k)
                0: emit(1, $urandom_range(0, 3), 0, ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, 255));
                1, 2, 3, 4, 5: emit(k + 1, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 255));
                6: emit(7, $urandom_range(0, 3), 0, $urandom_range(0, 63));
                7: emit(8, $urandom_range(0, 3), 0, $urandom_range(0, 63));
                8: probe($urandom_range(0, 62));
                9: emit(10, $urandom_range(0, 3), $urandom_range(0, 3), 0);
                10: begin
                        sel = $urandom_range(0, 2);
                        emit((sel == 0) ? 0 : ((sel == 1) ? 13 : 14), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 255));
                    end
                default: begin
                        emit(9, 0, 0, pa + 2);
                        emit(8, 0, 0, $urandom_range(0, 63));
                    end
            endcase
        end
        dump(8'h50);
        probe(8'h54);
        emit(15, 0, 0, 0);
    endtask

    initial begin
        int t;
        rst_n = 1'b0;
        foreach (dmem[i]) dmem[i] = 8'($urandom);
        clear_rom();
        #12;
        check_reset_outputs("por");

        // Reset asserted during EXEC of LDI r1,0x55.
        emit(1, 1, 0, 8'h55);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("fetch_pc", prog_addr, 8'h01);
        #2 rst_n = 1'b0;
        #1;
        check_reset_outputs("rst_exec");
        @(negedge clk);

        // Arithmetic: ADD carry, SUB rd==rs, reset state of regs/flags.
        clear_rom();
        dump(8'h40); probe(8'h44);
        emit(1, 0, 0, 8'hF0); emit(1, 1, 0, 8'h20); emit(2, 0, 1, 0);
        probe(8'h46); emit(8, 0, 0, 8'h10);
        emit(3, 1, 1, 0); probe(8'h48); emit(8, 1, 0, 8'h11);
        emit(15, 0, 0, 0);
        run_prog("arith");

        // Memory with 3 wait states per command.
        clear_rom();
        fixed_lat = 3;
        emit(1, 2, 0, 8'hA5); emit(8, 2, 0, 8'h30); emit(7, 3, 0, 8'h30);
        probe(8'h50); emit(8, 3, 0, 8'h31); emit(15, 0, 0, 0);
        run_prog("mem");
        fixed_lat = -1;

        // Branch: JZ not taken, JMP 0xFF, wrap to 0, JZ taken.
        clear_rom();
        emit(11, 0, 0, 8'h20); emit(9, 0, 0, 8'hFF);
        rom[8'hFF] = {4'h1, 2'd0, 2'd0, 8'h00};
        pa = 8'h20;
        emit(8, 0, 0, 8'h60); probe(8'h61); emit(15, 0, 0, 0);
        run_prog("branch");

        // HLT at 0x07.
        clear_rom();
        emit(1, 0, 0, 8'h11); emit(1, 1, 0, 8'h22); emit(0, 0, 0, 0); emit(13, 2, 3, 8'h44);
        emit(14, 1, 1, 8'h55); emit(1, 3, 0, 8'h00); emit(0, 0, 0, 0); emit(15, 0, 0, 0);
        run_prog("halt");

        // Opcode A (MUL when enabled, NOP otherwise).
        clear_rom();
        emit(1, 0, 0, 8'h10); emit(1, 1, 0, 8'h20); emit(10, 0, 1, 0);
        probe(8'h58); emit(8, 0, 0, 8'h5A); emit(15, 0, 0, 0);
        run_prog("opt_a");

        // Reset during a stalled store.
        clear_rom();
        emit(1, 2, 0, 8'h77); emit(8, 2, 0, 8'h05);
        fixed_lat = 50;
        @(negedge clk);
        rst_n = 1'b1;
        t = 0;
        while (mem_cmd === 2'b00 && t < 20) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("abort_cmd_issued", mem_cmd, 2'b10);
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check_reset_outputs("rst_mem");
        fixed_lat = -1;
        @(negedge clk);

        for (int p = 0; p < 8; p++) begin
            gen_random();
            run_prog($sformatf("rand%0d", p));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
